// File: rtl/btn_pkg.sv
// Shared definitions for the EGO1 button conditioning blocks: FSM state
// encodings and default 100 MHz debounce/long-press cycle counts.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned DB_CNT_DEFAULT   = 2000000;  // 20 ms at 100 MHz
    localparam int unsigned LONG_CNT_DEFAULT = 1000000;  // 10 ms at 100 MHz
    localparam int unsigned CNT_W_DEFAULT    = 21;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs (buttons, switches);
// output is the input delayed by two cp edges, reset value 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             cp,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronise, debounce, emit level plus one-cycle
// press/release pulses. Define BTN_LONG_PRESS_EN to enable long_pulse.
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int unsigned DB_CNT   = DB_CNT_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned LONG_CNT = LONG_CNT_DEFAULT
) (
    input  logic cp,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    if (DB_CNT < 2 || (64'd1 << CNT_W) <= 64'(DB_CNT) ||
        (64'd1 << CNT_W) <= 64'(LONG_CNT)) begin : g_bad_params
        $error("btn_debounce_pulse: illegal DB_CNT/CNT_W/LONG_CNT");
    end

    logic btn_s;

    sync_2ff #(.WIDTH(1)) u_sync (
        .cp    (cp),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (btn_s)
    );

    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, press_nxt, release_nxt;

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (btn_s) state_nxt = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                cnt_nxt = '0;
                if (!btn_s) state_nxt = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CNT);

    logic [CNT_W-1:0] hold_cnt;

    // Held at zero outside PRESSED so every entry (including a bounce back
    // from RELEASE_WAIT) restarts the count; parks at LONG_CNT after firing.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else if (state != ST_PRESSED) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else if (hold_cnt == LONG_LAST) begin
            hold_cnt   <= LONG_SAT;
            long_pulse <= 1'b1;
        end else begin
            if (hold_cnt != LONG_SAT) hold_cnt <= hold_cnt + 1'b1;
            long_pulse <= 1'b0;
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Upstream conditioning stage for the EGO1 push-button S1: synchronises the raw, bouncing button to the system clock, debounces it with a stability counter, and emits a clean level plus single-cycle press/release pulses.
- press_pulse drives the count input of the downstream mod-4 state counter, so one physical press gives exactly one count.
- Button is active-high, as on EGO1.

Parameters:
- DB_CNT, 2000000, cycles btn must stay stable to be accepted (20 ms at 100 MHz); must be >= 2.
- CNT_W, 21, counter width; must satisfy 2^CNT_W > DB_CNT and > LONG_CNT.
- LONG_CNT, 1000000, cycles held in PRESSED before long_pulse (used only with BTN_LONG_PRESS_EN).

Ports:
- cp  input  1  system clock, 100 MHz board oscillator
- rst_n  input  1  asynchronous active-low reset
- btn_raw  input  1  raw button pin (btn_1), asynchronous, bouncing
- btn_level  output  1  debounced button level
- press_pulse  output  1  one-cycle pulse on an accepted press
- release_pulse  output  1  one-cycle pulse on an accepted release
- long_pulse  output  1  one-cycle pulse on long hold (tied 0 without the macro)

Behaviour:
- Reset: one clock (cp); asynchronous, active-low reset (rst_n). While rst_n=0 all flops clear immediately: sync flops=0, cnt=0, state=IDLE, btn_level=0, press_pulse=0, release_pulse=0, long_pulse=0. Deassertion mid-bounce restarts from IDLE.
- Synchroniser: two flops; btn_s = btn_raw delayed 2 edges. Only btn_s is used by the FSM.
- FSM states, all outputs registered:
  - IDLE: btn_s=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT: btn_s=0 -> IDLE, cnt<=0 (bounce rejected, no pulse). btn_s=1 and cnt!=DB_CNT-1 -> cnt<=cnt+1. btn_s=1 and cnt==DB_CNT-1 -> PRESSED, btn_level<=1, press_pulse<=1 for one cycle, cnt<=0.
  - PRESSED: btn_s=0 -> RELEASE_WAIT, cnt<=0. Otherwise stay.
  - RELEASE_WAIT: btn_s=1 -> PRESSED, cnt<=0, no pulse. btn_s=0 and cnt==DB_CNT-1 -> IDLE, btn_level<=0, release_pulse<=1 for one cycle. Otherwise cnt<=cnt+1.
- Latency: with btn_raw first sampled high at edge 0 and held stable, press_pulse and btn_level rise after edge DB_CNT+2. Release is symmetric.
- Pulses are exactly one cycle wide. press_pulse and release_pulse are never high together.
- Any glitch shorter than DB_CNT cycles produces no output change.
- cnt never exceeds DB_CNT-1 and never wraps.
- Unused state encodings return to IDLE on the next edge.

Optional Feature:
- Macro: BTN_LONG_PRESS_EN.
- Defined:
  - A hold counter runs while the FSM is in PRESSED and clears on entry to PRESSED.
  - When the counter reaches LONG_CNT-1, long_pulse goes high for one cycle and the counter saturates, so there is only one long_pulse per press.
  - A bounce into RELEASE_WAIT and back to PRESSED restarts the hold count.
- Undefined: long_pulse is tied 0, no hold counter is synthesised, and the LONG_CNT parameter is ignored.

Decomposition:
- Shared package/header btn_pkg: state encodings ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1, ST_PRESSED=2'd2, ST_RELEASE_WAIT=2'd3. Default DB_CNT/LONG_CNT constants for 100 MHz.
- Sub-module sync_2ff: 2-flop synchroniser with cp and rst_n, reset value 0. It is reused for other EGO1 buttons and switches.
- FSM and counters stay in btn_debounce_pulse.

Test Plan (DB_CNT=4, LONG_CNT=8, CNT_W=4):
1. Clean press: btn_raw 0->1 held 20 cycles -> press_pulse high for exactly 1 cycle after edge 6; btn_level=1 from then on; release_pulse stays 0.
2. Bounce reject: btn_raw high 3 cycles, low 1, high 2, then low -> no press_pulse, btn_level stays 0, FSM back in IDLE.
3. Clean release: after test 1, btn_raw 1->0 held -> release_pulse single cycle after edge 6 of release; btn_level=0. A 2-cycle low glitch while pressed gives no release_pulse.
4. Reset mid-operation: rst_n=0 asynchronously during PRESS_WAIT (cnt=2) -> all outputs 0 immediately with no clock. After rst_n=1 with btn_raw high, press_pulse appears 6 edges later.
5. Downstream count: 5 clean presses -> exactly 5 press_pulses, so the mod-4 counter sequence is 00,01,10,11,00 with z high only on the 4th.
6. With BTN_LONG_PRESS_EN: hold 20 cycles past acceptance -> one long_pulse 8 cycles after press_pulse and none after. Without the macro, long_pulse=0 throughout.
